// File: rtl/RS5_pkg.sv
// Shared types for the atomic-memory-operation responder: the atomic op
// encoding used by the core, the responder FSM states and request decoding.
package RS5_pkg;

  // One-hot atomic operation selector driven by the core decoder.
  typedef enum logic [9:0] {
    AMONOP  = 10'b00_0000_0001,
    AMOSWAP = 10'b00_0000_0010,
    AMOADD  = 10'b00_0000_0100,
    AMOXOR  = 10'b00_0000_1000,
    AMOAND  = 10'b00_0001_0000,
    AMOOR   = 10'b00_0010_0000,
    AMOMIN  = 10'b00_0100_0000,
    AMOMAX  = 10'b00_1000_0000,
    AMOMINU = 10'b01_0000_0000,
    AMOMAXU = 10'b10_0000_0000
  } iTypeAtomic_e;

  // Responder sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } amoStates_e;

  // Resolved request kind after applying precedence among the request flags.
  typedef enum logic [2:0] {
    REQ_LOAD  = 3'd0,
    REQ_STORE = 3'd1,
    REQ_AMO   = 3'd2,
    REQ_LR    = 3'd3,
    REQ_SC    = 3'd4
  } req_kind_e;

  localparam logic [3:0]  BE_WORD     = 4'hF;
  localparam logic [31:0] SC_FAIL_VAL = 32'd1;

  // SC wins over LR, LR over AMO, AMO over a plain store; otherwise a load.
  function automatic req_kind_e decode_req(input logic         sc,
                                           input logic         lr,
                                           input logic         we,
                                           input iTypeAtomic_e op);
    if (sc)                 return REQ_SC;
    else if (lr)            return REQ_LR;
    else if (op != AMONOP)  return REQ_AMO;
    else if (we)            return REQ_STORE;
    else                    return REQ_LOAD;
  endfunction

endpackage

// File: rtl/amo_responder_if.sv
// Core request/response handshake plus the single-ported memory interface
// of the atomic responder, bundled into one interface.
interface amo_responder_if;
  import RS5_pkg::*;

  // Core request side
  logic         req_i;
  logic         ready_o;
  logic         we_i;
  logic [3:0]   be_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic         lr_i;
  logic         sc_i;
  iTypeAtomic_e amo_op_i;
  logic         clear_rsv_i;

  // Core response side
  logic         rsp_valid_o;
  logic [31:0]  rsp_rdata_o;
  logic         rsp_err_o;

  // Memory port
  logic         mem_en_o;
  logic [3:0]   mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [31:0]  mem_rdata_i;

  // Responder view
  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, lr_i, sc_i, amo_op_i,
           clear_rsv_i, mem_rdata_i,
    output ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Core + memory view
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, lr_i, sc_i, amo_op_i,
           clear_rsv_i, mem_rdata_i,
    input  ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/amo_alu.sv
// Combinational read-modify-write function for atomic memory operations.
module amo_alu
  import RS5_pkg::*;
(
  input  iTypeAtomic_e op,
  input  logic [31:0]  old,
  input  logic [31:0]  operand,
  output logic [31:0]  result
);

  // Select the new memory value; MIN/MAX keep the old value on a tie.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    result = old;
    case (op)
      AMOSWAP: result = operand;
      AMOADD:  result = old + operand;
      AMOXOR:  result = old ^ operand;
      AMOAND:  result = old & operand;
      AMOOR:   result = old | operand;
      AMOMIN:  result = ($signed(operand) < $signed(old)) ? operand : old;
      AMOMAX:  result = ($signed(operand) > $signed(old)) ? operand : old;
      AMOMINU: result = (operand < old) ? operand : old;
      AMOMAXU: result = (operand > old) ? operand : old;
      default: result = old;
    endcase
  end

endmodule

// File: rtl/amo_responder.sv
// Memory-side responder for plain loads/stores, LR/SC and AMOs.
// Sequences each request through IDLE -> (READ) -> (WRITE) -> RESP against a
// single-ported memory with one cycle of read latency, and tracks a single
// LR reservation.
module amo_responder
  import RS5_pkg::*;
(
  input logic            clk,
  input logic            reset,
  amo_responder_if.slave bus
);

  // FSM and registered outputs
  amoStates_e   r_state;
  logic         r_ready;
  logic         r_rsp_valid;
  logic         r_rsp_err;
  logic [31:0]  r_rsp_rdata;
  logic         r_rsp_from_mem;
  logic         r_mem_en;
  logic [3:0]   r_mem_we;
  logic [31:0]  r_mem_addr;
  logic [31:0]  r_mem_wdata;
  logic         r_amo_wr;
  req_kind_e    r_kind;
  iTypeAtomic_e r_op;

  // Reservation
  logic         r_rsv_valid;
  logic [29:0]  r_rsv_addr;

  // Decode of the incoming request
  req_kind_e    w_kind;
  logic         w_accept;
  logic         w_misaligned;
  logic         w_sc_ok;
  logic [31:0]  w_word_addr;
  logic [31:0]  w_alu_result;

  // Resolve request kind, alignment and SC outcome for the current request.
  always_comb begin
    w_kind       = decode_req(bus.sc_i, bus.lr_i, bus.we_i, bus.amo_op_i);
    w_accept     = bus.req_i && r_ready;
    w_misaligned = (w_kind inside {REQ_AMO, REQ_LR, REQ_SC}) && (bus.addr_i[1:0] != 2'b00);
    w_sc_ok      = r_rsv_valid && (r_rsv_addr == bus.addr_i[31:2]);
    w_word_addr  = {bus.addr_i[31:2], 2'b00};
  end

  // The old value arrives on mem_rdata_i during WRITE, so the new value is
  // computed combinationally from it in that same cycle.
  amo_alu u_amo_alu (
    .op      (r_op),
    .old     (bus.mem_rdata_i),
    .operand (r_mem_wdata),
    .result  (w_alu_result)
  );

  // Request sequencer with registered memory and response outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state        <= IDLE;
      r_ready        <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_from_mem <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_amo_wr       <= 1'b0;
      r_kind         <= REQ_LOAD;
      r_op           <= AMONOP;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready     <= 1'b0;
            r_kind      <= w_kind;
            r_op        <= bus.amo_op_i;
            r_mem_wdata <= bus.wdata_i;
            r_mem_addr  <= (w_kind inside {REQ_LOAD, REQ_STORE}) ? bus.addr_i : w_word_addr;
            if (w_misaligned) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              case (w_kind)
                REQ_SC: begin
                  if (w_sc_ok) begin
                    r_state  <= WRITE;
                    r_mem_en <= 1'b1;
                    r_mem_we <= BE_WORD;
                  end else begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= SC_FAIL_VAL;
                  end
                end
                REQ_STORE: begin
                  r_state  <= WRITE;
                  r_mem_en <= 1'b1;
                  r_mem_we <= bus.be_i;
                end
                default: begin
                  r_state  <= READ;
                  r_mem_en <= 1'b1;
                  r_mem_we <= '0;
                end
              endcase
            end
          end
        end

        READ: begin
          if (r_kind == REQ_AMO) begin
            r_state  <= WRITE;
            r_mem_we <= BE_WORD;
            r_amo_wr <= 1'b1;
          end else begin
            r_state        <= RESP;
            r_mem_en       <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_from_mem <= 1'b1;
          end
        end

        WRITE: begin
          r_state     <= RESP;
          r_mem_en    <= 1'b0;
          r_mem_we    <= '0;
          r_amo_wr    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= (r_kind == REQ_AMO) ? bus.mem_rdata_i : '0;
        end

        RESP: begin
          r_state        <= IDLE;
          r_ready        <= 1'b1;
          r_rsp_valid    <= 1'b0;
          r_rsp_err      <= 1'b0;
          r_rsp_from_mem <= 1'b0;
          r_rsp_rdata    <= '0;
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Reservation: kill sources outrank the LR set taken in READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsv_valid <= 1'b0;
      r_rsv_addr  <= '0;
    end else if (bus.clear_rsv_i) begin
      r_rsv_valid <= 1'b0;
    end else if (w_accept && (w_kind == REQ_SC) && !w_misaligned) begin
      r_rsv_valid <= 1'b0;
    end else if ((r_state == WRITE) && (r_mem_addr[31:2] == r_rsv_addr)) begin
      r_rsv_valid <= 1'b0;
    end else if ((r_state == READ) && (r_kind == REQ_LR)) begin
      r_rsv_valid <= 1'b1;
      r_rsv_addr  <= r_mem_addr[31:2];
    end
  end

  assign bus.ready_o     = r_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_rdata_o = r_rsp_from_mem ? bus.mem_rdata_i : r_rsp_rdata;
  assign bus.mem_en_o    = r_mem_en;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_amo_wr ? w_alu_result : r_mem_wdata;

endmodule

// File: tb/tb_amo_responder.sv
// Directed bench for amo_responder: a vector table of single requests with
// hand-computed responses and memory contents, plus hand-written reset and
// reservation corner sequences.
module tb_amo_responder;
  import RS5_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  amo_responder_if bus ();

  amo_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word-addressed memory model with one cycle of read latency.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we_o[b])
            mem[bus.mem_addr_o[11:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= mem[bus.mem_addr_o[11:2]];
      end
    end
  end

  typedef struct {
    string        name;
    logic         we;
    logic [3:0]   be;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         lr;
    logic         sc;
    iTypeAtomic_e op;
    logic         clr_pre;
    logic         clr_read;
    int           exp_lat;
    int           exp_wr_k;
    logic [31:0]  exp_rdata;
    logic         exp_err;
    logic         exp_en;
    logic [31:0]  exp_mem;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic lr, input logic sc, input iTypeAtomic_e op,
                              input logic clr_pre, input logic clr_read,
                              input int lat, input int wr_k, input logic [31:0] rdata,
                              input logic err, input logic en, input logic [31:0] memv);
    vec_t v;
    v.name = nm; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.lr = lr; v.sc = sc; v.op = op; v.clr_pre = clr_pre; v.clr_read = clr_read;
    v.exp_lat = lat; v.exp_wr_k = wr_k; v.exp_rdata = rdata; v.exp_err = err;
    v.exp_en = en; v.exp_mem = memv;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0; bus.addr_i = '0;
    bus.wdata_i = '0; bus.lr_i = 1'b0; bus.sc_i = 1'b0; bus.amo_op_i = AMONOP;
  endtask

  // Issue one request from a negedge in IDLE, follow it to RESP, then return
  // at the next negedge with the DUT back in IDLE.
  task automatic run_vec(input vec_t v);
    int          lat, wr_k;
    logic        saw_en, got, err;
    logic [31:0] rd, ad, exp_ad;
    lat = 0; wr_k = 0; saw_en = 1'b0; got = 1'b0; err = 1'b0; rd = '0; ad = '0;
    exp_ad = (v.sc || v.lr || v.op != AMONOP) ? {v.addr[31:2], 2'b00} : v.addr;
    if (v.clr_pre) begin
      bus.clear_rsv_i = 1'b1;
      @(negedge clk);
      bus.clear_rsv_i = 1'b0;
    end
    check({v.name, " ready"}, {31'd0, bus.ready_o}, 32'd1);
    bus.req_i = 1'b1; bus.we_i = v.we; bus.be_i = v.be; bus.addr_i = v.addr;
    bus.wdata_i = v.wdata; bus.lr_i = v.lr; bus.sc_i = v.sc; bus.amo_op_i = v.op;
    @(posedge clk);
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        idle_inputs();
        bus.clear_rsv_i = v.clr_read;
      end else begin
        bus.clear_rsv_i = 1'b0;
      end
      if (bus.mem_en_o) saw_en = 1'b1;
      if (bus.mem_we_o != 4'b0000 && wr_k == 0) wr_k = k;
      if (bus.rsp_valid_o) begin
        got = 1'b1; lat = k; rd = bus.rsp_rdata_o; err = bus.rsp_err_o; ad = bus.mem_addr_o;
      end
    end
    bus.clear_rsv_i = 1'b0;
    if (!got) begin
      check({v.name, " response timeout"}, 32'd0, 32'd1);
    end else begin
      check({v.name, " latency"},  lat, v.exp_lat);
      check({v.name, " rdata"},    rd, v.exp_rdata);
      check({v.name, " err"},      {31'd0, err}, {31'd0, v.exp_err});
      check({v.name, " mem_en"},   {31'd0, saw_en}, {31'd0, v.exp_en});
      check({v.name, " wr_cycle"}, wr_k, v.exp_wr_k);
      check({v.name, " mem_addr"}, ad, exp_ad);
      check({v.name, " mem_word"}, mem[v.addr[11:2]], v.exp_mem);
    end
    @(negedge clk);
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_evt;
    reset = 1'b1;
    bus.clear_rsv_i = 1'b0;
    idle_inputs();

    // -------- vector table --------
    //         name          we   be    addr          wdata         lr   sc   op       pre  rd   lat wr  rdata         err  en   mem
    tv.push_back(mk("st100",    1, 4'hF, 32'h100, 32'h7FFF_FFFF, 0, 0, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'h7FFF_FFFF));
    tv.push_back(mk("ld100",    0, 4'hF, 32'h100, 32'h0,         0, 0, AMONOP,  0, 0, 2, 0, 32'h7FFF_FFFF, 0, 1, 32'h7FFF_FFFF));
    tv.push_back(mk("amoadd",   0, 4'h0, 32'h100, 32'h1,         0, 0, AMOADD,  0, 0, 3, 2, 32'h7FFF_FFFF, 0, 1, 32'h8000_0000));
    tv.push_back(mk("st104",    1, 4'hF, 32'h104, 32'hFFFF_FFFE, 0, 0, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'hFFFF_FFFE));
    tv.push_back(mk("amomin",   0, 4'h0, 32'h104, 32'h5,         0, 0, AMOMIN,  0, 0, 3, 2, 32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFE));
    tv.push_back(mk("amominu",  0, 4'h0, 32'h104, 32'h5,         0, 0, AMOMINU, 0, 0, 3, 2, 32'hFFFF_FFFE, 0, 1, 32'h5));
    tv.push_back(mk("amomax",   0, 4'h0, 32'h104, 32'hFFFF_FFFD, 0, 0, AMOMAX,  0, 0, 3, 2, 32'h5,         0, 1, 32'h5));
    tv.push_back(mk("amomaxu",  0, 4'h0, 32'h104, 32'hFFFF_FFFD, 0, 0, AMOMAXU, 0, 0, 3, 2, 32'h5,         0, 1, 32'hFFFF_FFFD));
    tv.push_back(mk("amoxor",   0, 4'h0, 32'h104, 32'h0000_FFFF, 0, 0, AMOXOR,  0, 0, 3, 2, 32'hFFFF_FFFD, 0, 1, 32'hFFFF_0002));
    tv.push_back(mk("amoand",   0, 4'h0, 32'h104, 32'h0F0F_0F0F, 0, 0, AMOAND,  0, 0, 3, 2, 32'hFFFF_0002, 0, 1, 32'h0F0F_0002));
    tv.push_back(mk("amoor",    0, 4'h0, 32'h104, 32'h3000_0000, 0, 0, AMOOR,   0, 0, 3, 2, 32'h0F0F_0002, 0, 1, 32'h3F0F_0002));
    tv.push_back(mk("amoswap",  0, 4'h0, 32'h104, 32'h1234_5678, 0, 0, AMOSWAP, 0, 0, 3, 2, 32'h3F0F_0002, 0, 1, 32'h1234_5678));
    tv.push_back(mk("amomaxneg",0, 4'h0, 32'h104, 32'h8000_0000, 0, 0, AMOMAX,  0, 0, 3, 2, 32'h1234_5678, 0, 1, 32'h1234_5678));
    tv.push_back(mk("st108",    1, 4'hF, 32'h108, 32'hAABB_CCDD, 0, 0, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'hAABB_CCDD));
    tv.push_back(mk("stb10a",   1, 4'h4, 32'h10A, 32'h0011_0000, 0, 0, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'hAA11_CCDD));
    tv.push_back(mk("ld10a",    0, 4'h0, 32'h10A, 32'h0,         0, 0, AMONOP,  0, 0, 2, 0, 32'hAA11_CCDD, 0, 1, 32'hAA11_CCDD));
    tv.push_back(mk("st200",    1, 4'hF, 32'h200, 32'h11,        0, 0, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'h11));
    tv.push_back(mk("lr200",    0, 4'h0, 32'h200, 32'h0,         1, 0, AMONOP,  0, 0, 2, 0, 32'h11,        0, 1, 32'h11));
    tv.push_back(mk("sc_ok",    0, 4'h0, 32'h200, 32'hA5,        0, 1, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'hA5));
    tv.push_back(mk("sc_again", 0, 4'h0, 32'h200, 32'h99,        0, 1, AMONOP,  0, 0, 1, 0, 32'h1,         0, 0, 32'hA5));
    tv.push_back(mk("lr200b",   0, 4'h0, 32'h200, 32'h0,         1, 0, AMONOP,  0, 0, 2, 0, 32'hA5,        0, 1, 32'hA5));
    tv.push_back(mk("st202",    1, 4'h4, 32'h202, 32'h0077_0000, 0, 0, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'h0077_00A5));
    tv.push_back(mk("sc_kill_st",0,4'h0, 32'h200, 32'hFF,        0, 1, AMONOP,  0, 0, 1, 0, 32'h1,         0, 0, 32'h0077_00A5));
    tv.push_back(mk("lr200c",   0, 4'h0, 32'h200, 32'h0,         1, 0, AMONOP,  0, 0, 2, 0, 32'h0077_00A5, 0, 1, 32'h0077_00A5));
    tv.push_back(mk("sc_clr",   0, 4'h0, 32'h200, 32'hFF,        0, 1, AMONOP,  1, 0, 1, 0, 32'h1,         0, 0, 32'h0077_00A5));
    tv.push_back(mk("lr_clr_rd",0, 4'h0, 32'h200, 32'h0,         1, 0, AMONOP,  0, 1, 2, 0, 32'h0077_00A5, 0, 1, 32'h0077_00A5));
    tv.push_back(mk("sc_aft_clr",0,4'h0, 32'h200, 32'hFF,        0, 1, AMONOP,  0, 0, 1, 0, 32'h1,         0, 0, 32'h0077_00A5));
    tv.push_back(mk("amo_mis",  0, 4'h0, 32'h101, 32'hDEAD,      0, 0, AMOSWAP, 0, 0, 1, 0, 32'h0,         1, 0, 32'h8000_0000));
    tv.push_back(mk("lr200d",   0, 4'h0, 32'h200, 32'h0,         1, 0, AMONOP,  0, 0, 2, 0, 32'h0077_00A5, 0, 1, 32'h0077_00A5));
    tv.push_back(mk("sc_mis",   0, 4'h0, 32'h201, 32'hFF,        0, 1, AMONOP,  0, 0, 1, 0, 32'h0,         1, 0, 32'h0077_00A5));
    tv.push_back(mk("lr_mis",   0, 4'h0, 32'h203, 32'h0,         1, 0, AMONOP,  0, 0, 1, 0, 32'h0,         1, 0, 32'h0077_00A5));
    tv.push_back(mk("sc_keep",  0, 4'h0, 32'h200, 32'h5A,        0, 1, AMONOP,  0, 0, 2, 1, 32'h0,         0, 1, 32'h5A));
    tv.push_back(mk("prec_sc",  1, 4'hF, 32'h100, 32'h1,         1, 1, AMOADD,  0, 0, 1, 0, 32'h1,         0, 0, 32'h8000_0000));
    tv.push_back(mk("prec_lr",  1, 4'hF, 32'h100, 32'h1,         1, 0, AMOADD,  0, 0, 2, 0, 32'h8000_0000, 0, 1, 32'h8000_0000));
    tv.push_back(mk("prec_amo", 1, 4'hF, 32'h100, 32'h1,         0, 0, AMOSWAP, 0, 0, 3, 2, 32'h8000_0000, 0, 1, 32'h1));
    tv.push_back(mk("sc_kill_amo",0,4'h0,32'h100, 32'h77,        0, 1, AMONOP,  0, 0, 1, 0, 32'h1,         0, 0, 32'h1));
    tv.push_back(mk("ld102",    0, 4'h0, 32'h102, 32'h0,         0, 0, AMONOP,  0, 0, 2, 0, 32'h1,         0, 1, 32'h1));

    // -------- reset state --------
    repeat (3) @(negedge clk);
    check("rst ready",     {31'd0, bus.ready_o},     32'd1);
    check("rst rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata_o,          32'd0);
    check("rst rsp_err",   {31'd0, bus.rsp_err_o},   32'd0);
    check("rst mem_en",    {31'd0, bus.mem_en_o},    32'd0);
    check("rst mem_we",    {28'd0, bus.mem_we_o},    32'd0);
    check("rst mem_addr",  bus.mem_addr_o,           32'd0);
    check("rst mem_wdata", bus.mem_wdata_o,          32'd0);
    reset = 1'b0;
    @(negedge clk);

    // -------- table-driven vectors --------
    foreach (tv[i]) run_vec(tv[i]);

    // -------- reset during the READ of an AMO --------
    run_vec(mk("st300", 1, 4'hF, 32'h300, 32'h33, 0, 0, AMONOP, 0, 0, 2, 1, 32'h0,  0, 1, 32'h33));
    run_vec(mk("lr300", 0, 4'h0, 32'h300, 32'h0,  1, 0, AMONOP, 0, 0, 2, 0, 32'h33, 0, 1, 32'h33));
    bus.req_i = 1'b1; bus.amo_op_i = AMOADD; bus.addr_i = 32'h300; bus.wdata_i = 32'h5;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check("rst_amo read phase", {31'd0, bus.mem_en_o}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_amo ready",     {31'd0, bus.ready_o},     32'd1);
    check("rst_amo rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_amo mem_en",    {31'd0, bus.mem_en_o},    32'd0);
    n_evt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid_o || bus.mem_we_o != 4'b0000) n_evt++;
    end
    check("rst_amo quiet", n_evt, 0);
    check("rst_amo mem_word", mem[10'h0C0], 32'h33);
    run_vec(mk("sc_after_rst", 0, 4'h0, 32'h300, 32'hEE, 0, 1, AMONOP, 0, 0, 1, 0, 32'h1, 0, 0, 32'h33));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/amo_responder.md
AMO_RESPONDER -- requirements
Module: amo_responder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and address.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_i  input  1  core request valid.
REQ-005 ready_o  output  1  request accepted when req_i && ready_o.
REQ-006 we_i  input  1  plain store (1) or plain load (0).
REQ-007 be_i  input  4  byte enables for plain store.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data or AMO/SC operand.
REQ-010 lr_i, sc_i  input  1 each  LR.W / SC.W request.
REQ-011 amo_op_i  input  10  iTypeAtomic_e one-hot op; AMONOP means non-AMO.
REQ-012 clear_rsv_i  input  1  core-side reservation kill (trap/xRET).
REQ-013 rsp_valid_o  output  1  single-cycle response pulse; the core SHALL always accept it, with no backpressure.
REQ-014 rsp_rdata_o  output  32  load/LR/AMO old value, or SC status.
REQ-015 rsp_err_o  output  1  misaligned AMO/LR/SC.
REQ-016 mem_en_o, mem_we_o[3:0], mem_addr_o[31:0], mem_wdata_o[31:0]  output  registered memory port.
REQ-017 mem_rdata_i  input  32  valid exactly one cycle after a read (mem_en_o=1, mem_we_o=0).

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE and RESP; ready_o SHALL be 1 only in IDLE.
REQ-019 Plain load: accept at cycle N; READ at N+1 (mem_en_o=1, mem_we_o=0); RESP at N+2 with rsp_rdata_o=mem_rdata_i.
REQ-020 Plain store: N accept; WRITE at N+1 (mem_we_o=be_i, mem_wdata_o=wdata_i); RESP at N+2 with rsp_rdata_o=0.
REQ-021 AMO: N accept; READ at N+1; at N+2 WRITE captures old=mem_rdata_i and writes f(old, wdata_i) with mem_we_o=4'hF; RESP at N+3 with rsp_rdata_o=old.
REQ-022 f SHALL be: SWAP=operand; ADD mod 2^32; XOR/AND/OR bitwise; MIN/MAX signed; MINU/MAXU unsigned. On equal operands, MIN/MAX SHALL return old.
REQ-023 mem_addr_o SHALL be {addr[31:2],2'b00} for AMO, LR and SC, and addr_i for plain accesses; it SHALL be held from accept until RESP.
REQ-024 LR: behaves as a plain load, and in READ SHALL set rsv_valid=1 and rsv_addr=addr[31:2].
REQ-025 SC success (rsv_valid && rsv_addr==addr[31:2]): WRITE with 4'hF; RESP rdata=0.
REQ-026 SC failure: no memory access, IDLE->RESP directly (latency 1); RESP rdata=1.
REQ-027 Every SC SHALL clear rsv_valid, whatever its outcome.
REQ-028 Any WRITE-state write (store or AMO) to rsv_addr SHALL clear rsv_valid.
REQ-029 clear_rsv_i SHALL clear rsv_valid next cycle and SHALL take priority over a same-cycle LR set.
REQ-030 AMO, LR or SC with addr[1:0]!=0: no memory access, IDLE->RESP, rsp_err_o=1, rdata=0, reservation unchanged.
REQ-031 Precedence when several request kinds are asserted: sc_i > lr_i > AMO > we_i.
REQ-032 Outside READ and WRITE, mem_en_o=0 and mem_we_o=0; outside RESP, rsp_valid_o=0 and rsp_err_o=0.

Reset
REQ-033 Reset SHALL force the FSM to IDLE; ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; mem_en_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; rsv_valid=0.
REQ-034 Reset mid-operation SHALL abort the operation: no response is issued, a pending write is dropped if reset is sampled before WRITE, and ready_o=1 the next cycle.

Structure
REQ-035 amoStates_e {IDLE, READ, WRITE, RESP} SHALL be added to RS5_pkg; iTypeAtomic_e SHALL be reused from RS5_pkg.
REQ-036 f SHALL be a combinational sub-module amo_alu (inputs: op, old, operand; output: result).

Verification
REQ-037 mem[0x100]=0x7FFFFFFF; AMOADD addr 0x100, operand 1 -> write 0x80000000 at N+2; rdata 0x7FFFFFFF at N+3.
REQ-038 mem[0x104]=0xFFFFFFFE; AMOMIN operand 5 -> stored 0xFFFFFFFE. Same setup with AMOMINU -> stored 5.
REQ-039 LR 0x200, then SC 0x200 data 0xA5 -> rdata 0 and mem=0xA5. A second SC -> rdata 1, no mem_en_o.
REQ-040 LR 0x200, store to 0x202 with be_i=4'b0100, SC 0x200 -> rdata 1. Separately: LR 0x200, clear_rsv_i, SC -> rdata 1.
REQ-041 AMOSWAP at 0x101 -> RESP at N+1, rsp_err_o=1, mem_en_o never asserted.
REQ-042 Reset asserted during READ of an AMO -> no WRITE, no rsp_valid_o, ready_o=1 the next cycle, rsv_valid=0.
